// File: rtl/serial_borrow_lookahead_subtractor_pkg.sv
// Shared types and constants for the digit-serial borrow-lookahead subtractor.
// Optional flag outputs are enabled with the SUB_FLAGS_EN macro in the top.
package serial_borrow_lookahead_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DIGIT_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_borrow_lookahead_subtractor_lookahead.sv
// Combinational 4-bit borrow-lookahead cell computing a - b - borrow_in,
// with group propagate/generate exported for a future multi-level tree.
module borrow_lookahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       borrow_in,
  output logic [3:0] diff,
  output logic       borrow_out,
  output logic       grp_p,
  output logic       grp_g
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] br;

  // A borrow propagates when the bits are equal and is generated when a=0, b=1.
  always_comb begin
    p = ~(a ^ b);
    g = ~a & b;

    br[0] = borrow_in;
    br[1] = g[0] | (p[0] & borrow_in);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_in);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & borrow_in);

    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;

    borrow_out = grp_g | (grp_p & borrow_in);
    diff       = a ^ b ^ br;
  end

endmodule

// File: rtl/serial_borrow_lookahead_subtractor.sv
// Digit-serial subtractor: DIFF = A - B, one 4-bit digit per clock with a
// registered inter-digit borrow. Define SUB_FLAGS_EN to add ovf/zero outputs.
module serial_borrow_lookahead_subtractor
  import serial_borrow_lookahead_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  // WIDTH must be a multiple of DIGIT_W and at least DIGIT_W.
  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W  = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT_W-1:0] digit_diff;
  logic               digit_borrow;
  logic               grp_p;
  logic               grp_g;
  logic               unused_grp;

  borrow_lookahead_4bit u_cell (
    .a          (sa_q[DIGIT_W-1:0]),
    .b          (sb_q[DIGIT_W-1:0]),
    .borrow_in  (borrow_q),
    .diff       (digit_diff),
    .borrow_out (digit_borrow),
    .grp_p      (grp_p),
    .grp_g      (grp_g)
  );

  assign unused_grp = grp_p ^ grp_g;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Each new digit enters at the MSB end so the LSB digit lands at bit 0 last.
        sa_d     = sa_q >> DIGIT_W;
        sb_d     = sb_q >> DIGIT_W;
        diff_d   = (diff_q >> DIGIT_W) | (WIDTH'(digit_diff) << (WIDTH - DIGIT_W));
        borrow_d = digit_borrow;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;

`ifdef SUB_FLAGS_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic zero_acc_q, zero_acc_d;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  // Flags are finalised on the last digit so they update on the same edge as diff.
  always_comb begin
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    zero_acc_d = zero_acc_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    if (state_q == IDLE && in_valid) begin
      a_msb_d    = a[WIDTH-1];
      b_msb_d    = b[WIDTH-1];
      zero_acc_d = 1'b1;
    end else if (state_q == RUN) begin
      zero_acc_d = zero_acc_q & (digit_diff == '0);
      if (cnt_q == LAST_DIGIT) begin
        ovf_d  = (a_msb_q ^ b_msb_q) & (a_msb_q ^ digit_diff[DIGIT_W-1]);
        zero_d = zero_acc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      zero_acc_q <= zero_acc_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_borrow_lookahead_subtractor.sv
// Self-checking bench for serial_borrow_lookahead_subtractor (WIDTH=16);
// flag outputs are checked when SUB_FLAGS_EN is defined.
module tb_serial_borrow_lookahead_subtractor;

  localparam int WIDTH  = 16;
  localparam int DIGITS = WIDTH / 4;

  typedef struct {
    logic [15:0] d;
    logic        br;
    logic        ov;
    logic        z;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;
`ifdef SUB_FLAGS_EN
  logic        ovf;
  logic        zero;
`endif

  int   errors;
  int   checks;
  exp_t sb_q[$];

  serial_borrow_lookahead_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SUB_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
    exp_t        m;
    logic [16:0] full;
    full = {1'b0, av} - {1'b0, bv};
    m.d  = full[15:0];
    m.br = full[16];
    m.ov = (av[15] ^ bv[15]) & (av[15] ^ full[15]);
    m.z  = (full[15:0] == 16'h0000);
    return m;
  endfunction

  // Starts at a negedge with the DUT idle; returns at a negedge after handoff.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int hold);
    exp_t e;
    int   cycles;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    sb_q.push_back(model(av, bv));
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
      end
    end while (out_valid !== 1'b1 && cycles < 40);

    checks++;
    if (out_valid !== 1'b1 || (cycles - 1) != DIGITS) begin
      errors++;
      $display("FAIL latency: out_valid=%b after %0d edges expected 1 after %0d",
               out_valid, cycles - 1, DIGITS);
    end

    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow: size=0 expected >0");
      e = model(av, bv);
    end else begin
      e = sb_q.pop_front();
    end

    checks++;
    if (diff !== e.d || borrow !== e.br) begin
      errors++;
      $display("FAIL result a=%h b=%h: diff=%h borrow=%b expected diff=%h borrow=%b",
               av, bv, diff, borrow, e.d, e.br);
    end
`ifdef SUB_FLAGS_EN
    checks++;
    if (ovf !== e.ov || zero !== e.z) begin
      errors++;
      $display("FAIL flags a=%h b=%h: ovf=%b zero=%b expected ovf=%b zero=%b",
               av, bv, ovf, zero, e.ov, e.z);
    end
`endif
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_in_ready: in_ready=%b expected 0", in_ready);
    end

    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = (i % 2 == 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== e.d || borrow !== e.br) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b diff=%h borrow=%b expected 1 0 %h %b",
                 i, out_valid, in_ready, diff, borrow, e.d, e.br);
      end
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h borrow=%b expected 1 0 0000 0",
               in_ready, out_valid, diff, borrow);
    end
`ifdef SUB_FLAGS_EN
    checks++;
    if (ovf !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ovf=%b zero=%b expected 0 0", ovf, zero);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_plan_vectors();
    run_op(16'h1234, 16'h0234, 0);
    run_op(16'h0000, 16'h0001, 0);
    run_op(16'h1000, 16'h0001, 0);
    run_op(16'h8000, 16'h0001, 0);
    run_op(16'h5A5A, 16'h5A5A, 0);
    run_op(16'h7FFF, 16'hFFFF, 0);
    run_op(16'hFFFF, 16'h0000, 0);
  endtask

  task automatic test_backpressure();
    run_op(16'h0000, 16'h0001, 5);
    run_op(16'h8000, 16'h7FFF, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_op(16'($urandom), 16'($urandom), i % 3);
    end
  endtask

  task automatic test_reset_midop();
    a        = 16'h1111;
    b        = 16'h0001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b diff=%h borrow=%b expected 1 0 0000 0",
               in_ready, out_valid, diff, borrow);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midop_no_result_%0d: out_valid=%b in_ready=%b expected 0 1",
                 i, out_valid, in_ready);
      end
    end
    run_op(16'h0005, 16'h0003, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_plan_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: size=%0d expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
